uart_rx_param: RTL and testbench

Parametrised UART receiver for the serial-peripheral subsystem.
- Runtime-selectable 5–8 data bits, none/even/odd parity, and 1 or 2 stop bits.
- 3-sample majority voting; false start bits are rejected.
- Built-in show-ahead receive FIFO of configurable depth; each entry carries its own frame/parity error flags.
- Sits between the board rxd pin and the register/CPU side; replaces the fixed 8-bit receiver in new designs.

---
 rtl/uart_rx_param.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: UART receiver with runtime 5-8 data bits, parity and stop selection, 3-sample voting and a show-ahead RX FIFO.
// Define UART_RX_BREAK_DET_EN to add the break_det output and keep break frames out of the FIFO.
module uart_rx_param #(
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic [BAUD_W-1:0] baudrate,
  input  logic [1:0]        data_bits,
  input  logic [1:0]        parity_sel,
  input  logic              stop_sel,
  input  logic              rxd,
  input  logic              ren,
  input  logic              ovr_clr,
  output logic [7:0]        rdata,
  output logic              rvalid,
  output logic              rd_frame_err,
  output logic              rd_parity_err,
  output logic              overrun,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              busy,
  output logic [1:0]        debug_state
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic              break_det
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [BAUD_W-1:0] ONE = BAUD_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t            r_state;
  logic [2:0]        r_sync;
  logic [BAUD_W-1:0] r_baud, r_cnt;
  logic [2:0]        r_lastIdx, r_bitIdx;
  logic              r_parEn, r_parOdd, r_stop2, r_inPar, r_parBit;
  logic [1:0]        r_stopIdx;
  logic              r_stopDone, r_ferr, r_brk, r_brkDet;
  logic [7:0]        r_data;
  logic              r_s0, r_s1;

  logic              w_rx, w_fall, w_maj, w_atEnd, w_atSample, w_brkCand, w_brkNow;
  logic              w_push, w_perr;
  logic [BAUD_W-1:0] w_mid, w_nextCnt;
  logic [1:0]        w_lastStop;

  assign w_rx       = r_sync[1];
  assign w_fall     = r_sync[2] & ~r_sync[1];
  assign w_mid      = r_baud >> 1;
  assign w_atSample = (r_cnt == w_mid + ONE);
  assign w_atEnd    = (r_cnt == r_baud);
  assign w_nextCnt  = w_atEnd ? '0 : r_cnt + ONE;
  assign w_maj      = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_lastStop = {1'b0, r_stop2};
  assign w_perr     = r_parEn & (^r_data ^ r_parBit ^ r_parOdd);

`ifdef UART_RX_BREAK_DET_EN
  assign w_brkCand = (r_data == 8'd0) & ~(r_parEn & r_parBit);
`else
  assign w_brkCand = 1'b0;
`endif
  // A break is decided on the first stop sample and then held until the line votes high again.
  assign w_brkNow = (r_stopIdx == 2'd0) ? (w_brkCand & ~w_maj) : r_brk;
  assign w_push   = (r_state == STOP) & r_stopDone & ~r_brk;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_sync     <= 3'b111;
      r_baud     <= '0;
      r_cnt      <= '0;
      r_lastIdx  <= 3'd0;
      r_bitIdx   <= 3'd0;
      r_parEn    <= 1'b0;
      r_parOdd   <= 1'b0;
      r_stop2    <= 1'b0;
      r_inPar    <= 1'b0;
      r_parBit   <= 1'b0;
      r_stopIdx  <= 2'd0;
      r_stopDone <= 1'b0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
      r_brkDet   <= 1'b0;
      r_data     <= 8'd0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
    end else begin
      r_sync   <= {r_sync[1:0], rxd};
      r_brkDet <= 1'b0;
      if (r_cnt == w_mid - ONE) r_s0 <= w_rx;
      if (r_cnt == w_mid)       r_s1 <= w_rx;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state    <= START;
            r_cnt      <= '0;
            r_baud     <= baudrate;
            r_lastIdx  <= {1'b1, data_bits};
            r_parEn    <= (parity_sel == 2'b01) || (parity_sel == 2'b10);
            r_parOdd   <= (parity_sel == 2'b10);
            r_stop2    <= stop_sel;
            r_bitIdx   <= 3'd0;
            r_inPar    <= 1'b0;
            r_parBit   <= 1'b0;
            r_data     <= 8'd0;
            r_stopIdx  <= 2'd0;
            r_stopDone <= 1'b0;
            r_ferr     <= 1'b0;
            r_brk      <= 1'b0;
          end
        end
        START: begin
          r_cnt <= w_nextCnt;
          if (w_atSample && w_maj) r_state <= IDLE;
          else if (w_atEnd)       r_state <= DATA;
        end
        DATA: begin
          r_cnt <= w_nextCnt;
          if (w_atSample) begin
            if (r_inPar) r_parBit <= w_maj;
            else         r_data[r_bitIdx] <= w_maj;
          end
          if (w_atEnd) begin
            if (!r_inPar && r_bitIdx != r_lastIdx) r_bitIdx <= r_bitIdx + 3'd1;
            else if (!r_inPar && r_parEn)         r_inPar  <= 1'b1;
            else                                  r_state  <= STOP;
          end
        end
        STOP: begin
          if (r_stopDone) begin
            r_state  <= IDLE;
            r_brkDet <= r_brk;
          end else begin
            r_cnt <= w_nextCnt;
            if (w_atSample) begin
              if (r_stopIdx <= w_lastStop && !w_maj) r_ferr <= 1'b1;
              r_brk <= w_brkNow;
              if (w_brkNow ? (w_maj && r_stopIdx >= w_lastStop) : (r_stopIdx == w_lastStop))
                r_stopDone <= 1'b1;
            end
            if (w_atEnd && r_stopIdx != 2'd2) r_stopIdx <= r_stopIdx + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic [9:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wrPtr, r_rdPtr;
  logic [LVL_W-1:0] r_level;
  logic             r_ovr;
  logic             w_pop, w_full, w_wr;

  assign w_pop  = ren & (r_level != '0);
  assign w_full = (r_level == LVL_W'(FIFO_DEPTH));
  // A push into a full FIFO still lands when the head is popped in the same cycle.
  assign w_wr   = w_push & (~w_full | w_pop);

  always_ff @(posedge mclk) begin
    if (w_wr) r_mem[r_wrPtr] <= {r_ferr, w_perr, r_data};
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_wr)  r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop) r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_push && w_full && !w_pop) r_ovr <= 1'b1;
      else if (ovr_clr)               r_ovr <= 1'b0;
    end
  end

  assign rvalid        = (r_level != '0);
  assign rdata         = rvalid ? r_mem[r_rdPtr][7:0] : 8'd0;
  assign rd_parity_err = rvalid & r_mem[r_rdPtr][8];
  assign rd_frame_err  = rvalid & r_mem[r_rdPtr][9];
  assign overrun       = r_ovr;
  assign fifo_level    = r_level;
  assign busy          = (r_state != IDLE);
  assign debug_state   = r_state;
`ifdef UART_RX_BREAK_DET_EN
  assign break_det     = r_brkDet;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed, table-driven bench for uart_rx_param (default build, FIFO_DEPTH=4, baudrate=15).
module tb_uart_rx_param;

  localparam int DEPTH = 4;
  localparam int BAUD  = 15;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          mclk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   baudrate = 16'(BAUD);
  logic [1:0]    data_bits = 2'b11;
  logic [1:0]    parity_sel = 2'b00;
  logic          stop_sel = 1'b0;
  logic          rxd = 1'b1;
  logic          ren = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [7:0]    rdata;
  logic          rvalid, rd_frame_err, rd_parity_err, overrun, busy;
  logic [LW-1:0] fifo_level;
  logic [1:0]    debug_state;

  int testsRun = 0;
  int testsFailed = 0;

  uart_rx_param #(.FIFO_DEPTH(DEPTH), .BAUD_W(16)) dut (
    .mclk(mclk), .reset(reset), .baudrate(baudrate), .data_bits(data_bits),
    .parity_sel(parity_sel), .stop_sel(stop_sel), .rxd(rxd), .ren(ren), .ovr_clr(ovr_clr),
    .rdata(rdata), .rvalid(rvalid), .rd_frame_err(rd_frame_err), .rd_parity_err(rd_parity_err),
    .overrun(overrun), .fifo_level(fifo_level), .busy(busy), .debug_state(debug_state)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] dbits;
    logic [1:0] par;
    logic       stop2;
    logic       flip;
    logic       stopVal;
    int         spike;
    logic [7:0] expData;
    logic       expFerr;
    logic       expPerr;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveBit(input logic v, input int spikeAt);
    for (int c = 0; c <= BAUD; c++) begin
      @(negedge mclk);
      rxd = (c == spikeAt) ? ~v : v;
    end
  endtask

  // Drives one whole frame (start, data, optional parity, stop bits) followed by a short idle gap.
  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] db, input logic [1:0] ps,
                               input logic s2, input logic flip, input logic stopVal, input int spikeBit);
    int n;
    logic p;
    data_bits  = db;
    parity_sel = ps;
    stop_sel   = s2;
    n = 5 + int'(db);
    p = 1'b0;
    driveBit(1'b0, -1);
    for (int i = 0; i < n; i++) begin
      p = p ^ d[i];
      driveBit(d[i], (spikeBit == i) ? 8 : -1);
    end
    if (ps == 2'b01 || ps == 2'b10) driveBit(p ^ (ps == 2'b10) ^ flip, -1);
    driveBit(stopVal, -1);
    if (s2) driveBit(1'b1, -1);
    for (int c = 0; c < 4; c++) begin
      @(negedge mclk);
      rxd = 1'b1;
    end
  endtask

  task automatic waitValid(input string name);
    int n;
    n = 0;
    while (!rvalid && n < 400) begin
      @(negedge mclk);
      n++;
    end
    checkOutput({name, "_valid"}, int'(rvalid), 1);
  endtask

  task automatic popHead();
    @(negedge mclk);
    ren = 1'b1;
    @(negedge mclk);
    ren = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit prevBusy, seen;

    //            data   db     par    s2    flip  stop  spike expD   fe    pe
    vecs[0]  = '{8'hA5, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, -1,  8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{8'h55, 2'b10, 2'b01, 1'b1, 1'b0, 1'b1, -1,  8'h55, 1'b0, 1'b0};
    vecs[2]  = '{8'h55, 2'b10, 2'b01, 1'b1, 1'b1, 1'b1, -1,  8'h55, 1'b0, 1'b1};
    vecs[3]  = '{8'h1F, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, -1,  8'h1F, 1'b1, 1'b0};
    vecs[4]  = '{8'h0A, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, -1,  8'h0A, 1'b0, 1'b0};
    vecs[5]  = '{8'h2B, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, -1,  8'h2B, 1'b0, 1'b0};
    vecs[6]  = '{8'h00, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1, -1,  8'h00, 1'b0, 1'b0};
    vecs[7]  = '{8'hC3, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 3,   8'hC3, 1'b0, 1'b0};
    vecs[8]  = '{8'h00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, -1,  8'h00, 1'b1, 1'b0};
    vecs[9]  = '{8'hFF, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, -1,  8'h1F, 1'b0, 1'b0};
    vecs[10] = '{8'h6C, 2'b01, 2'b10, 1'b1, 1'b1, 1'b1, -1,  8'h2C, 1'b0, 1'b1};

    repeat (3) @(negedge mclk);
    checkOutput("rst_rvalid", int'(rvalid), 0);
    checkOutput("rst_rdata", int'(rdata), 0);
    checkOutput("rst_level", int'(fifo_level), 0);
    checkOutput("rst_overrun", int'(overrun), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_state", int'(debug_state), 0);
    reset = 1'b1;
    repeat (5) @(negedge mclk);

    // Latency: the entry must appear on the same cycle the receiver drops back to IDLE.
    data_bits = 2'b11; parity_sel = 2'b00; stop_sel = 1'b0;
    driveBit(1'b0, -1);
    for (int i = 0; i < 8; i++) driveBit(1'(8'hA5 >> i), -1);
    prevBusy = 1'b1;
    seen = 1'b0;
    for (int c = 0; c <= BAUD; c++) begin
      @(negedge mclk);
      rxd = 1'b1;
      if (!seen && prevBusy && !busy) begin
        seen = 1'b1;
        checkOutput("lat_rvalid", int'(rvalid), 1);
        checkOutput("lat_level", int'(fifo_level), 1);
      end else if (!seen && rvalid) begin
        checkOutput("lat_early_rvalid", int'(rvalid), 0);
      end
      prevBusy = busy;
    end
    checkOutput("lat_seen", int'(seen), 1);
    checkOutput("lat_rdata", int'(rdata), 8'hA5);
    popHead();
    checkOutput("lat_pop_rvalid", int'(rvalid), 0);
    popHead();
    checkOutput("empty_ren_level", int'(fifo_level), 0);
    checkOutput("empty_ren_rvalid", int'(rvalid), 0);

    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].data, vecs[v].dbits, vecs[v].par, vecs[v].stop2,
                    vecs[v].flip, vecs[v].stopVal, vecs[v].spike);
      waitValid($sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d_rdata", v), int'(rdata), int'(vecs[v].expData));
      checkOutput($sformatf("vec%0d_ferr", v), int'(rd_frame_err), int'(vecs[v].expFerr));
      checkOutput($sformatf("vec%0d_perr", v), int'(rd_parity_err), int'(vecs[v].expPerr));
      checkOutput($sformatf("vec%0d_level", v), int'(fifo_level), 1);
      popHead();
      checkOutput($sformatf("vec%0d_pop", v), int'(rvalid), 0);
    end

    // Two-cycle low glitch while idle: START is entered, then abandoned without a push.
    repeat (10) @(negedge mclk);
    @(negedge mclk); rxd = 1'b0;
    @(negedge mclk);
    @(negedge mclk); rxd = 1'b1;
    @(negedge mclk);
    checkOutput("glitch_start", int'(debug_state), 1);
    repeat (30) @(negedge mclk);
    checkOutput("glitch_idle", int'(debug_state), 0);
    checkOutput("glitch_level", int'(fifo_level), 0);

    // Overrun: five frames into a four-entry FIFO.
    for (int f = 1; f <= 5; f++) applyStimulus(8'(f), 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, -1);
    repeat (20) @(negedge mclk);
    checkOutput("ovr_level", int'(fifo_level), 4);
    checkOutput("ovr_flag", int'(overrun), 1);
    for (int f = 1; f <= 4; f++) begin
      checkOutput($sformatf("ovr_head%0d", f), int'(rdata), f);
      popHead();
    end
    checkOutput("ovr_empty", int'(rvalid), 0);
    checkOutput("ovr_sticky", int'(overrun), 1);
    @(negedge mclk); ovr_clr = 1'b1;
    @(negedge mclk); ovr_clr = 1'b0;
    checkOutput("ovr_cleared", int'(overrun), 0);

    // Reset in the middle of a data bit with two entries stored.
    applyStimulus(8'h11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, -1);
    applyStimulus(8'h22, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, -1);
    checkOutput("mid_level", int'(fifo_level), 2);
    driveBit(1'b0, -1);
    for (int i = 0; i < 3; i++) driveBit(1'(8'h3C >> i), -1);
    @(negedge mclk); reset = 1'b0;
    @(negedge mclk);
    checkOutput("mid_rst_rvalid", int'(rvalid), 0);
    checkOutput("mid_rst_rdata", int'(rdata), 0);
    checkOutput("mid_rst_level", int'(fifo_level), 0);
    checkOutput("mid_rst_ferr", int'(rd_frame_err), 0);
    checkOutput("mid_rst_perr", int'(rd_parity_err), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_state", int'(debug_state), 0);
    rxd = 1'b1;
    repeat (3) @(negedge mclk);
    reset = 1'b1;
    repeat (20) @(negedge mclk);
    applyStimulus(8'h3C, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, -1);
    waitValid("post_rst");
    checkOutput("post_rst_rdata", int'(rdata), 8'h3C);
    checkOutput("post_rst_level", int'(fifo_level), 1);
    popHead();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
